// File: rtl/fusion_accumulator.sv
// Lane-split accumulator for fused products: sums 1/2/4 lanes of a 16-bit
// product stream over a programmable number of beats and hands the result downstream.
module fusion_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic [1:0]         mode,
    input  logic               signed_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] out_data,
    output logic               busy,
    output logic               err
);

    // state | meaning
    // IDLE  | waiting for start; rejects mode 11 with an err pulse
    // ACCUM | accepting beats until the down-counter reaches terminal count
    // DRAIN | holding the result until out_ready
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic [1:0]     MODE_BAD = 2'b11;
    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

    state_t           state;
    logic [LEN_W:0]   cnt;
    logic [1:0]       mode_q;
    logic             signed_q;
    logic [ACC_W-1:0] acc    [4];
    logic [ACC_W-1:0] addend [4];

    always_comb begin
        for (int i = 0; i < 4; i++) addend[i] = '0;
        case (mode_q)
            2'b00: begin
                for (int i = 0; i < 4; i++)
                    addend[i] = {{(ACC_W-4){signed_q & in_data[4*i+3]}}, in_data[4*i +: 4]};
            end
            2'b01: begin
                for (int i = 0; i < 2; i++)
                    addend[i] = {{(ACC_W-8){signed_q & in_data[8*i+7]}}, in_data[8*i +: 8]};
            end
            2'b10: addend[0] = {{(ACC_W-16){signed_q & in_data[15]}}, in_data};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= '0;
            signed_q  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_BAD) begin
                            err <= 1'b1;
                        end else begin
                            mode_q   <= mode;
                            signed_q <= signed_in;
                            cnt      <= (len == '0) ? CNT_FULL : {1'b0, len};
                            for (int i = 0; i < 4; i++) acc[i] <= '0;
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        for (int i = 0; i < 4; i++) acc[i] <= acc[i] + addend[i];
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) out_data[ACC_W*i +: ACC_W] = acc[i];
    end

endmodule
